// File: rtl/dl_pkg.sv
// dl_pkg: shared types and helpers for the Duursma-Lee loop control.
//   dl_state_e  - sequencer state encoding (IDLE must stay 0)
//   D_ZERO/D_ONE/D_TWO - 2-bit encodings of the GF(3) coefficient d
//   gf3_dec     - d-1 mod 3 on that encoding
//   M_DEFAULT   - default field extension degree
package dl_pkg;

  localparam int M_DEFAULT = 97;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_DLY    = 3'd2,
    S_F3M    = 3'd3,
    S_F36M   = 3'd4,
    S_STEP   = 3'd5,
    S_FINISH = 3'd6
  } dl_state_e;

  localparam logic [1:0] D_ZERO = 2'b00;
  localparam logic [1:0] D_ONE  = 2'b01;
  localparam logic [1:0] D_TWO  = 2'b10;

  // 1 -> 0 -> 2 -> 1; the unused code 11 falls back to 2.
  function automatic logic [1:0] gf3_dec(input logic [1:0] v);
    case (v)
      D_ONE:   gf3_dec = D_ZERO;
      D_ZERO:  gf3_dec = D_TWO;
      D_TWO:   gf3_dec = D_ONE;
      default: gf3_dec = D_TWO;
    endcase
  endfunction

endpackage

// File: rtl/dl_watchdog.sv
// dl_watchdog: cycle counter for bounding a wait on a multiplier.
//   clk, reset - clock, synchronous active-high reset
//   clr        - restart the count (has priority over en)
//   en         - count this cycle
//   tmo        - high in the (2^TMO_W-1)-th consecutive enabled cycle
//                since the last clear
module dl_watchdog #(
  parameter int TMO_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tmo
);

  localparam logic [TMO_W-1:0] ALL1 = '1;
  localparam logic [TMO_W-1:0] LAST = ALL1 - 1'b1;

  logic [TMO_W-1:0] cnt;

  // cnt holds the number of enabled cycles already completed, so the
  // cycle in which the count would reach all-ones is flagged directly.
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end

  assign tmo = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/dl_loop_sequencer.sv
// dl_loop_sequencer: control for the Duursma-Lee Miller loop over GF(3^M).
//   clk, reset        - clock, synchronous active-high reset
//   start, n_iter     - run request (IDLE only) and step count sampled with it
//   abort             - cancel a run, back to IDLE without capture
//   f3m_go/f3m_done   - GF(3^m) multiplier launch pulse / result ready
//   f36m_go/f36m_done - GF(3^6m) multiplier launch pulse / result ready
//   init_load         - pulse: load initial operands
//   step_load         - pulse: commit one loop step
//   capture           - pulse: latch final t
//   d                 - current GF(3) coefficient
//   iter              - steps completed
//   busy, done, err   - status levels (err = multiplier timeout)
module dl_loop_sequencer
  import dl_pkg::*;
#(
  parameter int M      = M_DEFAULT,
  parameter int ITER_W = 8,
  parameter int DELAY  = 2,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              abort,
  output logic              f3m_go,
  input  logic              f3m_done,
  output logic              f36m_go,
  input  logic              f36m_done,
  output logic              init_load,
  output logic              step_load,
  output logic              capture,
  output logic [1:0]        d,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // M travels with the instance for the datapath; reject nonsense values.
  if (M < 1 || DELAY < 1 || DELAY > 15) begin : g_bad_param
    $error("dl_loop_sequencer: parameter out of range");
  end

  localparam logic [3:0] DLY_LAST = 4'(DELAY - 1);

  dl_state_e         state;
  logic [ITER_W-1:0] n_q;
  logic [ITER_W-1:0] iter_inc;
  logic [3:0]        dly_cnt;
  logic              wait_st, leave, wd_clr, wd_tmo;

  assign iter_inc = iter + 1'b1;

  // Watchdog restarts whenever we are not waiting or are about to leave
  // the wait state, so it reads zero in the first cycle of F3M / F36M.
  assign wait_st = (state == S_F3M) || (state == S_F36M);
  assign leave   = abort
                 | ((state == S_F3M)  & f3m_done)
                 | ((state == S_F36M) & f36m_done);
  assign wd_clr  = ~wait_st | leave;

  dl_watchdog #(.TMO_W(TMO_W)) u_wd (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wait_st),
    .tmo   (wd_tmo)
  );

  // Pulses are raised on the edge that enters their state, so each one
  // lines up with the first (or only) cycle of that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      n_q       <= '0;
      dly_cnt   <= '0;
      d         <= D_ONE;
      iter      <= '0;
      f3m_go    <= 1'b0;
      f36m_go   <= 1'b0;
      init_load <= 1'b0;
      step_load <= 1'b0;
      capture   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      f3m_go    <= 1'b0;
      f36m_go   <= 1'b0;
      init_load <= 1'b0;
      step_load <= 1'b0;
      capture   <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start && !abort) begin
            state     <= S_INIT;
            n_q       <= n_iter;
            iter      <= '0;
            d         <= D_ONE;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            init_load <= 1'b1;
          end
          S_INIT: begin
            dly_cnt <= '0;
            if (n_q == '0) begin
              state   <= S_FINISH;
              capture <= 1'b1;
            end else begin
              state <= S_DLY;
            end
          end
          S_DLY: begin
            if (dly_cnt == DLY_LAST) begin
              state  <= S_F3M;
              f3m_go <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end
          S_F3M: begin
            if (f3m_done) begin
              state   <= S_F36M;
              f36m_go <= 1'b1;
            end else if (wd_tmo) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
          S_F36M: begin
            if (f36m_done) begin
              state     <= S_STEP;
              step_load <= 1'b1;
            end else if (wd_tmo) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
          S_STEP: begin
            d       <= gf3_dec(d);
            iter    <= iter_inc;
            dly_cnt <= '0;
            if (iter_inc == n_q) begin
              state   <= S_FINISH;
              capture <= 1'b1;
            end else begin
              state <= S_DLY;
            end
          end
          S_FINISH: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dl_loop_sequencer.sv
// tb_dl_loop_sequencer: table-driven runs plus hand-written corner cases
// for dl_loop_sequencer. A responder answers the multiplier launches with
// fixed latencies; a scoreboard queue holds the expected (d, iter) seen at
// each step_load.
module tb_dl_loop_sequencer;

  localparam int ITER_W   = 8;
  localparam int DELAY    = 2;
  localparam int TMO_W    = 4;
  localparam int F3M_LAT  = 5;
  localparam int F36M_LAT = 10;

  logic              clk = 1'b0;
  logic              reset, start, abort, f3m_done, f36m_done;
  logic [ITER_W-1:0] n_iter;
  logic              f3m_go, f36m_go, init_load, step_load, capture;
  logic              busy, done, err;
  logic [1:0]        d;
  logic [ITER_W-1:0] iter;

  dl_loop_sequencer #(.M(97), .ITER_W(ITER_W), .DELAY(DELAY), .TMO_W(TMO_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_iter    (n_iter),
    .abort     (abort),
    .f3m_go    (f3m_go),
    .f3m_done  (f3m_done),
    .f36m_go   (f36m_go),
    .f36m_done (f36m_done),
    .init_load (init_load),
    .step_load (step_load),
    .capture   (capture),
    .d         (d),
    .iter      (iter),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk, n_fail;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard of expected state at each step_load.
  typedef struct { logic [1:0] d; int iter; } step_t;
  step_t sb_q[$];
  logic [1:0] d_seq [3] = '{2'b01, 2'b00, 2'b10};

  task automatic push_steps(input int n);
    step_t e;
    for (int i = 0; i < n; i++) begin
      e.d    = d_seq[i % 3];
      e.iter = i;
      sb_q.push_back(e);
    end
  endtask

  // Monitor counters, relative to t0 (the cycle start was driven in).
  int t0;
  int m_f3m, m_f36m, m_step, m_cap, m_cap_rel, m_f3m_rel;
  bit resp_f3m_en = 1'b1;
  bit stray_req   = 1'b0;

  task automatic clr_mon();
    m_f3m = 0; m_f36m = 0; m_step = 0; m_cap = 0; m_cap_rel = -1; m_f3m_rel = -1;
  endtask

  // Monitor + multiplier responder, all on the falling edge.
  initial begin
    int f3m_cnt, f36m_cnt;
    logic [4:0] prev;
    step_t e;
    f3m_done = 1'b0; f36m_done = 1'b0; prev = '0; f3m_cnt = 0; f36m_cnt = 0;
    forever begin
      @(negedge clk);
      if (f3m_go) begin
        m_f3m++;
        if (m_f3m == 1) m_f3m_rel = cyc - t0;
        check("f3m_go_width", prev[0], 0);
      end
      if (f36m_go) begin m_f36m++; check("f36m_go_width", prev[1], 0); end
      if (init_load) check("init_load_width", prev[2], 0);
      if (step_load) begin
        m_step++;
        check("step_load_width", prev[3], 0);
        if (sb_q.size() == 0) check("step_unexpected", step_load, 0);
        else begin
          e = sb_q.pop_front();
          check("step_d", d, e.d);
          check("step_iter", iter, e.iter);
        end
      end
      if (capture) begin
        m_cap++; m_cap_rel = cyc - t0;
        check("capture_width", prev[4], 0);
      end
      prev = {capture, step_load, init_load, f36m_go, f3m_go};

      f3m_done = 1'b0; f36m_done = 1'b0;
      if (!busy) begin f3m_cnt = 0; f36m_cnt = 0; end
      if (f3m_cnt > 0) begin f3m_cnt--; if (f3m_cnt == 0) f3m_done = 1'b1; end
      if (f36m_cnt > 0) begin f36m_cnt--; if (f36m_cnt == 0) f36m_done = 1'b1; end
      if (f3m_go && resp_f3m_en) f3m_cnt = F3M_LAT;
      if (f36m_go) f36m_cnt = F36M_LAT;
      if (stray_req) f36m_done = 1'b1;
    end
  end

  // Drive start at negedge+1; returns in cycle 1 of the run.
  task automatic kick(input int n);
    n_iter = n[ITER_W-1:0]; start = 1'b1; t0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    check("init_load_c1", init_load, 1);
    check("busy_c1", busy, 1);
    check("err_clr_c1", err, 0);
    check("done_clr_c1", done, 0);
  endtask

  task automatic wait_idle(output int rel);
    rel = -1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (!busy) begin rel = cyc - t0; break; end
    end
    if (rel < 0) check("idle_timeout", busy, 0);
  endtask

  task automatic wait_mon(input bit on_step, input int k);
    int c;
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      c = on_step ? m_step : m_f36m;
      if (c >= k) return;
    end
    check(on_step ? "wait_step" : "wait_f36m", c, k);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_d"}, d, 2'b01);
    check({tag, "_iter"}, iter, 0);
    check({tag, "_pulses"}, {f3m_go, f36m_go, init_load, step_load, capture}, 0);
  endtask

  task automatic run(input int n, input logic [1:0] exp_d, input int exp_done);
    int rel;
    clr_mon();
    push_steps(n);
    kick(n);
    wait_idle(rel);
    check("done_latency", rel, exp_done);
    check("done", done, 1);
    check("err", err, 0);
    check("iter", iter, n);
    check("d_final", d, exp_d);
    check("f3m_go_count", m_f3m, n);
    check("f36m_go_count", m_f36m, n);
    check("step_count", m_step, n);
    check("capture_count", m_cap, 1);
    check("capture_cycle", m_cap_rel, exp_done - 1);
    check("sb_empty", sb_q.size(), 0);
    if (n > 0) check("first_f3m_go", m_f3m_rel, DELAY + 2);
  endtask

  // n, final d, cycle (from start) in which done=1/busy=0 first shows.
  // Step period with these latencies is 18+DELAY; last step ends 19 after its f3m_go.
  typedef struct { int n; logic [1:0] exp_d; int exp_done; } vec_t;
  vec_t vecs [5];

  initial begin
    int rel;
    vecs[0] = '{3, 2'b01, 63};
    vecs[1] = '{0, 2'b01, 3};
    vecs[2] = '{1, 2'b00, 23};
    vecs[3] = '{2, 2'b10, 43};
    vecs[4] = '{4, 2'b00, 83};

    reset = 1'b1; start = 1'b0; abort = 1'b0; n_iter = '0;
    clr_mon();
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk); #1;

    foreach (vecs[i]) run(vecs[i].n, vecs[i].exp_d, vecs[i].exp_done);

    // Abort in the second F36M of a 4-step run, then a clean 4-step run.
    clr_mon();
    push_steps(1);
    kick(4);
    wait_mon(1'b0, 2);
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_iter", iter, 1);
    check("abort_d", d, 2'b00);
    repeat (15) @(negedge clk);
    #1;
    check("abort_no_capture", m_cap, 0);
    check("abort_steps", m_step, 1);
    check("abort_sb_empty", sb_q.size(), 0);
    run(4, 2'b00, 83);

    // f3m_done never comes: watchdog fires after 2^TMO_W-1 cycles in F3M.
    resp_f3m_en = 1'b0;
    clr_mon();
    kick(2);
    wait_idle(rel);
    check("tmo_latency", rel, DELAY + 2 + (2**TMO_W - 1));
    check("tmo_err", err, 1);
    check("tmo_done", done, 0);
    check("tmo_capture", m_cap, 0);
    check("tmo_f36m_go", m_f36m, 0);
    resp_f3m_en = 1'b1;
    run(1, 2'b00, 23);

    // start re-pulsed with another n_iter and a stray f36m_done, both in DLY.
    clr_mon();
    push_steps(3);
    kick(3);
    wait_mon(1'b1, 1);
    @(negedge clk); #1;
    start = 1'b1; n_iter = 8'd7; stray_req = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; stray_req = 1'b0;
    wait_idle(rel);
    check("repulse_latency", rel, 63);
    check("repulse_iter", iter, 3);
    check("repulse_steps", m_step, 3);
    check("repulse_f36m_go", m_f36m, 3);
    check("repulse_capture", m_cap, 1);
    check("repulse_done", done, 1);
    check("repulse_sb_empty", sb_q.size(), 0);

    // reset together with abort and start while in STEP.
    clr_mon();
    push_steps(1);
    kick(2);
    wait_mon(1'b1, 1);
    reset = 1'b1; abort = 1'b1; start = 1'b1; n_iter = 8'd5;
    @(negedge clk); #1;
    check_reset_vals("midrst");
    reset = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("midrst_steps", m_step, 1);
    check("midrst_capture", m_cap, 0);
    check("midrst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dl_loop_sequencer.md
Name: dl_loop_sequencer

Overview:
- Parametrised control sequencer for the Duursma–Lee Miller loop over GF(3^M), the next generation of the fixed-97-bit loop control.
- Owns iteration counting, the GF(3) coefficient d, launch pulses for the GF(3^m) and GF(3^6m) multipliers, the per-step register-load strobe and the final-capture strobe.
- Adds a start/done handshake, a runtime iteration count, abort, and a multiplier watchdog.
- Sits between the pairing top and the existing datapath units; it holds no field-element data itself.

Parameters:
- M, 97, field extension degree; informational only, exported for the datapath.
- ITER_W, 8, width of the iteration count and counter.
- DELAY, 2, idle cycles between a step boundary and the f3m launch (operand settle); legal range 1..15.
- TMO_W, 16, watchdog counter width; timeout fires after 2^TMO_W-1 cycles waiting in one state.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; all state and outputs return to their reset values at the next clk edge.
- start  in  1  request a run; accepted only in IDLE.
- n_iter  in  ITER_W  number of loop steps; sampled when start is accepted.
- abort  in  1  cancel the current run.
- f3m_go  out  1  one-cycle launch pulse for the GF(3^m) multipliers.
- f3m_done  in  1  GF(3^m) product ready; honoured only in state F3M.
- f36m_go  out  1  one-cycle launch pulse for the GF(3^6m) multiplier.
- f36m_done  in  1  GF(3^6m) product ready; honoured only in state F36M.
- init_load  out  1  pulse: load the initial operands (a, b, t=1, y, d).
- step_load  out  1  pulse: commit the step results (a, b, t, y, d).
- capture  out  1  pulse: latch the final t as the pairing output.
- d  out  2  current GF(3) coefficient: 00=0, 01=1, 10=2.
- iter  out  ITER_W  number of steps completed.
- busy  out  1  high in every state except IDLE.
- done  out  1  level; set after capture.
- err  out  1  level; set on watchdog timeout.

Behaviour:
- Reset values: state=IDLE, d=01, iter=0; every pulse output, busy, done and err are 0.
- States: IDLE, INIT, DLY, F3M, F36M, STEP, FINISH.
- IDLE -> INIT on start & !abort. The same edge samples n_iter, clears done, err and iter, and sets d=01.
- INIT (1 cycle, init_load=1): goes to FINISH if n_iter==0, else to DLY.
- DLY: stays exactly DELAY cycles, then goes to F3M.
- F3M: f3m_go=1 in its first cycle only. Moves to F36M in the cycle after f3m_done is sampled high.
- F36M: f36m_go=1 in its first cycle only. Moves to STEP in the cycle after f36m_done is sampled high.
- STEP (1 cycle, step_load=1):
  - d becomes d-1 mod 3 (01->00->10->01; illegal 11 -> 10).
  - iter increments.
  - Next state is FINISH if the new iter equals n_iter, else DLY.
- FINISH (1 cycle, capture=1): then IDLE with done=1.
- Latency: start sampled at edge 0 gives init_load in cycle 1 and f3m_go in cycle DELAY+2. f36m_done high in cycle j gives step_load in j+1. On the final step, capture is in j+2, and done=1 with busy=0 from cycle j+3.
- Pulse outputs are registered and never stretch beyond one cycle.
- Watchdog: cleared on entry to F3M or F36M and counts each cycle spent in that state. At all-ones it sets err=1 and returns to IDLE with no capture; done stays 0.
- Boundary rules:
  - abort in any non-IDLE state: IDLE next cycle, no capture, done=0, err unchanged, d and iter hold their values.
  - abort together with start in IDLE: start ignored.
  - start while busy: ignored, and n_iter is not resampled.
  - Stray f3m_done or f36m_done in other states: ignored.
  - done and capture both requested in one cycle cannot occur; the FINISH/IDLE split guarantees this.
  - reset mid-run: overrides everything, including abort and start.

Decomposition:
- Package dl_pkg holds:
  - the state enum with a fixed binary encoding (IDLE=0);
  - the GF(3) encodings D_ZERO, D_ONE, D_TWO;
  - a mod-3 decrement function;
  - default M.
- One sub-module: dl_watchdog (TMO_W counter with clear/enable inputs and a terminal flag), reused by the later final-exponentiation sequencer.

Test Plan:
- n_iter=3, DELAY=2, f3m_done 5 cycles after each f3m_go, f36m_done 10 cycles after each f36m_go -> exactly 3 f3m_go, 3 f36m_go and 3 step_load pulses; d sequence 01,00,10,01; iter=3; one capture pulse; done=1; start-to-done latency matches the formula.
- n_iter=0 -> init_load, then capture two cycles after start; no go pulses; done=1, iter=0.
- abort asserted during the second F36M of an n_iter=4 run -> IDLE next cycle; no capture; done=0; iter=1; a following start runs 4 clean steps.
- f3m_done held low with TMO_W=4 -> err=1 and busy=0 after 15 cycles in F3M; next start clears err.
- start re-pulsed mid-run with a different n_iter, plus a stray f36m_done during DLY -> no effect; original run completes with the original count.
- reset asserted in STEP together with abort and start -> all outputs return to reset values next cycle; no step_load or capture afterwards.
